pulse_interval_meter: RTL and testbench

Sits directly downstream of the noise-filter stage and consumes its 1-cycle validated pulse output. Measures the clock-cycle interval between successive pulses and buffers intervals in a small FIFO. Buffered intervals drain over a valid/ready interface to the consumer. Also reports timeout (pulse train stopped), FIFO overflow and a running pulse count.

---
 rtl/pulse_interval_meter.sv | 154 +++++++++++++++
 tb/tb_pulse_interval_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_interval_meter.sv
// Pulse interval meter: times the gap between validated pulses and queues intervals in a small FIFO.
// Optional min/max tracking is built only when PIM_MINMAX_EN is defined.
module pulse_interval_meter #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pulse_in,
  input  logic                         clear,
  output logic                         iv_valid,
  input  logic                         iv_ready,
  output logic [CNT_W-1:0]             iv_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         timeout,
  output logic [15:0]                  pulse_total,
  output logic [CNT_W-1:0]             min_iv,
  output logic [CNT_W-1:0]             max_iv
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               push;
  logic               timeout_hit;

  logic [CNT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_FW-1:0]  count_reg;
  logic               overflow_reg, timeout_reg;
  logic [15:0]        total_reg;

  logic               full, pop, wr_en, drop;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    push        = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (pulse_in) begin
          state_next = MEASURE;
          cnt_next   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (pulse_in) begin
          push     = 1'b1;
          cnt_next = CNT_W'(1);
        end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
          state_next  = IDLE;
          cnt_next    = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign full  = (count_reg == CNT_FW'(FIFO_DEPTH));
  assign pop   = iv_valid && iv_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
      total_reg    <= '0;
    end else if (clear) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
      total_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) overflow_reg <= 1'b1;
      if (pulse_in) begin
        timeout_reg <= 1'b0;
        total_reg   <= total_reg + 1'b1;
      end else if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr_reg] <= cnt_reg;
  end

  assign iv_valid    = (count_reg != '0);
  assign iv_data     = iv_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_count  = count_reg;
  assign overflow    = overflow_reg;
  assign timeout     = timeout_reg;
  assign pulse_total = total_reg;

`ifdef PIM_MINMAX_EN
  logic [CNT_W-1:0] min_reg, max_reg;

  // Dropped intervals still count towards the extremes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_reg <= '1;
      max_reg <= '0;
    end else if (clear) begin
      min_reg <= '1;
      max_reg <= '0;
    end else if (push) begin
      if (cnt_reg < min_reg) min_reg <= cnt_reg;
      if (cnt_reg > max_reg) max_reg <= cnt_reg;
    end
  end

  assign min_iv = min_reg;
  assign max_iv = max_reg;
`else
  assign min_iv = '0;
  assign max_iv = '0;
`endif

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed bench for pulse_interval_meter: a per-cycle vector table plus hand sequences
// for timeout and asynchronous reset / clear corner cases.
module tb_pulse_interval_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pulse_in;
  logic        clear;
  logic        iv_valid;
  logic        iv_ready;
  logic [15:0] iv_data;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        timeout;
  logic [15:0] pulse_total;
  logic [15:0] min_iv;
  logic [15:0] max_iv;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        pulse;
    logic        ready;
    logic        clr;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [2:0]  exp_count;
    logic        exp_ovf;
    logic        exp_to;
    logic [15:0] exp_total;
  } vec_t;

  vec_t vecs[$];

  pulse_interval_meter #(
    .CNT_W(16),
    .FIFO_DEPTH(4),
    .TIMEOUT(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pulse_in(pulse_in),
    .clear(clear),
    .iv_valid(iv_valid),
    .iv_ready(iv_ready),
    .iv_data(iv_data),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .timeout(timeout),
    .pulse_total(pulse_total),
    .min_iv(min_iv),
    .max_iv(max_iv)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic r, input logic c, input logic v,
                     input logic [15:0] d, input logic [2:0] n, input logic o,
                     input logic t, input logic [15:0] tot);
    vec_t e;
    e.pulse = p; e.ready = r; e.clr = c;
    e.exp_valid = v; e.exp_data = d; e.exp_count = n;
    e.exp_ovf = o; e.exp_to = t; e.exp_total = tot;
    vecs.push_back(e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, 32'(iv_valid), 32'd0);
    chk({tag, ".data"}, 32'(iv_data), 32'd0);
    chk({tag, ".count"}, 32'(fifo_count), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".to"}, 32'(timeout), 32'd0);
    chk({tag, ".total"}, 32'(pulse_total), 32'd0);
`ifdef PIM_MINMAX_EN
    chk({tag, ".min"}, 32'(min_iv), 32'hFFFF);
`else
    chk({tag, ".min"}, 32'(min_iv), 32'd0);
`endif
    chk({tag, ".max"}, 32'(max_iv), 32'd0);
  endtask

  initial begin
    // Pulses at relative cycles 5, 9, 12 with the consumer always ready.
    for (int i = 0; i < 5; i++) add(0,1,0, 0,0,0,0,0,0);
    add(1,1,0, 0,0,0,0,0,1);
    for (int i = 0; i < 3; i++) add(0,1,0, 0,0,0,0,0,1);
    add(1,1,0, 1,4,1,0,0,2);
    for (int i = 0; i < 2; i++) add(0,1,0, 0,0,0,0,0,2);
    add(1,1,0, 1,3,1,0,0,3);
    add(0,1,0, 0,0,0,0,0,3);
    add(0,0,1, 0,0,0,0,0,0);
    // Three back-to-back pulses from IDLE, consumer stalled, then drained.
    add(1,0,0, 0,0,0,0,0,1);
    add(1,0,0, 1,1,1,0,0,2);
    add(1,0,0, 1,1,2,0,0,3);
    add(0,0,0, 1,1,2,0,0,3);
    add(0,1,0, 1,1,1,0,0,3);
    add(0,1,0, 0,0,0,0,0,3);
    add(0,0,1, 0,0,0,0,0,0);
    // Six pulses spaced 2 apart into a stalled FIFO: fills, then overflows.
    add(1,0,0, 0,0,0,0,0,1);
    for (int k = 1; k <= 5; k++) begin
      add(0,0,0, k > 1, (k > 1) ? 16'd2 : 16'd0, 3'(k-1), 0, 0, 16'(k));
      add(1,0,0, 1, 16'd2, (k < 4) ? 3'(k) : 3'd4, k == 5, 0, 16'(k+1));
    end
    add(0,0,0, 1,2,4,1,0,6);
    for (int j = 3; j >= 0; j--) add(0,1,0, j > 0, (j > 0) ? 16'd2 : 16'd0, 3'(j), 1, 0, 6);
    add(0,0,1, 0,0,0,0,0,0);
    // Intervals 1,2,3,4 fill the FIFO; interval 5 arrives together with a pop.
    add(1,0,0, 0,0,0,0,0,1);
    add(1,0,0, 1,1,1,0,0,2);
    add(0,0,0, 1,1,1,0,0,2);
    add(1,0,0, 1,1,2,0,0,3);
    for (int i = 0; i < 2; i++) add(0,0,0, 1,1,2,0,0,3);
    add(1,0,0, 1,1,3,0,0,4);
    for (int i = 0; i < 3; i++) add(0,0,0, 1,1,3,0,0,4);
    add(1,0,0, 1,1,4,0,0,5);
    for (int i = 0; i < 4; i++) add(0,0,0, 1,1,4,0,0,5);
    add(1,1,0, 1,2,4,0,0,6);
    add(0,1,0, 1,3,3,0,0,6);
    add(0,1,0, 1,4,2,0,0,6);
    add(0,1,0, 1,5,1,0,0,6);
    add(0,1,0, 0,0,0,0,0,6);

    rst_n = 1'b0; pulse_in = 1'b0; clear = 1'b0; iv_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk_reset_state("reset");

    foreach (vecs[i]) begin
      pulse_in = vecs[i].pulse;
      iv_ready = vecs[i].ready;
      clear    = vecs[i].clr;
      tick();
      $display("vec %0d p=%0b r=%0b clr=%0b -> valid=%0b data=%0d count=%0d ovf=%0b total=%0d",
               i, pulse_in, iv_ready, clear, iv_valid, iv_data, fifo_count, overflow, pulse_total);
      chk($sformatf("v%0d.valid", i), 32'(iv_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d.data", i), 32'(iv_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d.count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("v%0d.to", i), 32'(timeout), 32'(vecs[i].exp_to));
      chk($sformatf("v%0d.total", i), 32'(pulse_total), 32'(vecs[i].exp_total));
    end
    pulse_in = 1'b0; iv_ready = 1'b0; clear = 1'b0;

    // Timeout: one pulse, then 1000 quiet cycles.
    clear = 1'b1; tick(); clear = 1'b0;
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    repeat (998) tick();
    $display("timeout seq: after 998 idle cycles to=%0b count=%0d", timeout, fifo_count);
    chk("to.early", 32'(timeout), 32'd0);
    repeat (2) tick();
    $display("timeout seq: after 1000 idle cycles to=%0b count=%0d", timeout, fifo_count);
    chk("to.set", 32'(timeout), 32'd1);
    chk("to.nopush", 32'(fifo_count), 32'd0);
    repeat (5) tick();
    chk("to.sticky", 32'(timeout), 32'd1);
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    $display("timeout seq: restart pulse to=%0b count=%0d total=%0d", timeout, fifo_count, pulse_total);
    chk("to.cleared", 32'(timeout), 32'd0);
    chk("to.restart_nopush", 32'(fifo_count), 32'd0);
    chk("to.total", 32'(pulse_total), 32'd2);
    repeat (6) tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    $display("timeout seq: next interval valid=%0b data=%0d", iv_valid, iv_data);
    chk("to.iv_valid", 32'(iv_valid), 32'd1);
    chk("to.iv_data", 32'(iv_data), 32'd7);

    // Asynchronous reset mid-measurement, away from any clock edge.
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    repeat (2) tick();
    #3 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%0b count=%0d total=%0d", iv_valid, fifo_count, pulse_total);
    chk_reset_state("arst");
    tick();
    rst_n = 1'b1;
    #2;
    pulse_in = 1'b1; tick();
    chk("pre_clear.total", 32'(pulse_total), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0; pulse_in = 1'b0;
    $display("clear+pulse: valid=%0b count=%0d total=%0d", iv_valid, fifo_count, pulse_total);
    chk_reset_state("clr");
    tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk("clr.idle_first_pulse_count", 32'(fifo_count), 32'd0);
    chk("clr.idle_first_pulse_total", 32'(pulse_total), 32'd1);
    repeat (2) tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    $display("post-clear interval: valid=%0b data=%0d", iv_valid, iv_data);
    chk("clr.iv_data", 32'(iv_data), 32'd3);
    chk("clr.count", 32'(fifo_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
